// File: rtl/zda_emitter_if.sv
// Byte-stream handshake and time/date field bundle between the time registers and zda_emitter.
interface zda_if;
    logic        start;
    logic        hold;
    logic [31:0] hhmmss;
    logic [7:0]  day;
    logic [7:0]  month;
    logic [15:0] year;
    logic [7:0]  zone_h;
    logic [7:0]  zone_m;
    logic        load;
    logic [7:0]  data;
    logic        busy;
    logic        done;

    modport master (
        output start, hold, hhmmss, day, month, year, zone_h, zone_m,
        input  load, data, busy, done
    );

    modport slave (
        input  start, hold, hhmmss, day, month, year, zone_h, zone_m,
        output load, data, busy, done
    );
endinterface

// File: rtl/zda_emitter.sv
// Serializes one NMEA $xxZDA sentence, one byte per clock, with running XOR checksum and hold.
module zda_emitter #(
    parameter logic [15:0] TALKER = "GP"
) (
    input  logic clock,
    input  logic restart,
    zda_if.slave bus
);
    localparam int unsigned IDX_W = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(37);
    localparam logic [IDX_W-1:0] CS_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] CS_LAST  = IDX_W'(32);

    typedef enum logic {IDLE, SEND} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, eidx_c;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       data_q, data_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       byte_c;
    logic             latch_c;
    logic             emit_c;

    logic [31:0] time_q;
    logic [7:0]  day_q, month_q, zh_q, zm_q;
    logic [15:0] year_q;

    function automatic logic [7:0] dig(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // The accept edge emits index 0 even though idx_q is stale in IDLE.
    assign eidx_c = (state_q == IDLE) ? '0 : idx_q;

    always_comb begin
        byte_c = 8'h00;
        case (eidx_c)
            6'd0:  byte_c = 8'h24;
            6'd1:  byte_c = TALKER[15:8];
            6'd2:  byte_c = TALKER[7:0];
            6'd3:  byte_c = 8'h5A;
            6'd4:  byte_c = 8'h44;
            6'd5:  byte_c = 8'h41;
            6'd6:  byte_c = 8'h2C;
            6'd7:  byte_c = dig(time_q[31:28]);
            6'd8:  byte_c = dig(time_q[27:24]);
            6'd9:  byte_c = dig(time_q[23:20]);
            6'd10: byte_c = dig(time_q[19:16]);
            6'd11: byte_c = dig(time_q[15:12]);
            6'd12: byte_c = dig(time_q[11:8]);
            6'd13: byte_c = 8'h2E;
            6'd14: byte_c = dig(time_q[7:4]);
            6'd15: byte_c = dig(time_q[3:0]);
            6'd16: byte_c = 8'h2C;
            6'd17: byte_c = dig(day_q[7:4]);
            6'd18: byte_c = dig(day_q[3:0]);
            6'd19: byte_c = 8'h2C;
            6'd20: byte_c = dig(month_q[7:4]);
            6'd21: byte_c = dig(month_q[3:0]);
            6'd22: byte_c = 8'h2C;
            6'd23: byte_c = dig(year_q[15:12]);
            6'd24: byte_c = dig(year_q[11:8]);
            6'd25: byte_c = dig(year_q[7:4]);
            6'd26: byte_c = dig(year_q[3:0]);
            6'd27: byte_c = 8'h2C;
            6'd28: byte_c = dig(zh_q[7:4]);
            6'd29: byte_c = dig(zh_q[3:0]);
            6'd30: byte_c = 8'h2C;
            6'd31: byte_c = dig(zm_q[7:4]);
            6'd32: byte_c = dig(zm_q[3:0]);
            6'd33: byte_c = 8'h2A;
            6'd34: byte_c = hex(csum_q[7:4]);
            6'd35: byte_c = hex(csum_q[3:0]);
            6'd36: byte_c = 8'h0D;
            6'd37: byte_c = 8'h0A;
            default: byte_c = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        data_d  = data_q;
        load_d  = 1'b0;
        done_d  = 1'b0;
        latch_c = 1'b0;
        emit_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    latch_c = 1'b1;
                    state_d = SEND;
                    idx_d   = '0;
                    csum_d  = '0;
                    emit_c  = 1'b1;
                end
            end
            SEND: emit_c = 1'b1;
        endcase

        // Hold freezes data and index; only load drops.
        if (emit_c && !bus.hold) begin
            load_d = 1'b1;
            data_d = byte_c;
            idx_d  = eidx_c + IDX_W'(1);
            if (eidx_c >= CS_FIRST && eidx_c <= CS_LAST) begin
                csum_d = csum_q ^ byte_c;
            end
            if (eidx_c == LAST_IDX) begin
                done_d  = 1'b1;
                state_d = IDLE;
                idx_d   = '0;
            end
        end

        busy_d = (state_d == SEND);
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            state_q <= IDLE;
            idx_q   <= '0;
            csum_q  <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Field snapshot; only read while a sentence is in flight.
    always_ff @(posedge clock) begin
        if (latch_c) begin
            time_q  <= bus.hhmmss;
            day_q   <= bus.day;
            month_q <= bus.month;
            year_q  <= bus.year;
            zh_q    <= bus.zone_h;
            zm_q    <= bus.zone_m;
        end
    end

    assign bus.load = load_q;
    assign bus.data = data_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_zda_emitter.sv
// Self-checking bench for zda_emitter: directed table, multi-cycle corner cases, random vs. sentence model.
module tb_zda_emitter;
    localparam logic [15:0] TK_GP = "GP";
    localparam logic [15:0] TK_GN = "GN";

    logic clock;
    logic restart;

    zda_if bus();
    zda_if bus_gn();

    assign bus_gn.start  = bus.start;
    assign bus_gn.hold   = bus.hold;
    assign bus_gn.hhmmss = bus.hhmmss;
    assign bus_gn.day    = bus.day;
    assign bus_gn.month  = bus.month;
    assign bus_gn.year   = bus.year;
    assign bus_gn.zone_h = bus.zone_h;
    assign bus_gn.zone_m = bus.zone_m;

    zda_emitter u_dut (.clock(clock), .restart(restart), .bus(bus));
    zda_emitter #(.TALKER("GN")) u_gn (.clock(clock), .restart(restart), .bus(bus_gn));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]  hms;
        logic [7:0]   dd;
        logic [7:0]   mo;
        logic [15:0]  yy;
        logic [7:0]   zh;
        logic [7:0]   zm;
        logic [303:0] gp;
        logic [303:0] gn;
    } vec_t;

    vec_t tbl [3];

    int total = 0;
    int bad   = 0;

    logic [7:0] cap[$];
    logic [7:0] capg[$];
    logic [7:0] exp_q[$];
    int cyc, first_cyc, done_cyc, busy_cnt, bubbles;

    task automatic check_eq(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_cap();
        cap = {};
        capg = {};
        cyc = 0;
        first_cyc = -1;
        done_cyc = -1;
        busy_cnt = 0;
        bubbles = 0;
    endtask

    // One clock; sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (bus.load) begin
            cap.push_back(bus.data);
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (bus_gn.load) capg.push_back(bus_gn.data);
        if (bus.done) begin
            done_cyc = cyc;
            check_eq("done_with_load", int'(bus.load), 1);
        end
        if (bus.busy) busy_cnt++;
        if (bus.busy && !bus.load) bubbles++;
    endtask

    task automatic push_num(input logic [31:0] v, input int nd);
        for (int i = nd - 1; i >= 0; i--) exp_q.push_back(8'h30 + 8'(v[i*4 +: 4]));
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n - 4'd10);
    endfunction

    // Builds the expected sentence from the field values as text, then appends checksum.
    task automatic model(input logic [15:0] tk, input logic [31:0] hms, input logic [7:0] dd,
                         input logic [7:0] mo, input logic [15:0] yy, input logic [7:0] zh,
                         input logic [7:0] zm);
        logic [7:0] cs;
        exp_q = {};
        exp_q.push_back("$");
        exp_q.push_back(tk[15:8]);
        exp_q.push_back(tk[7:0]);
        exp_q.push_back("Z"); exp_q.push_back("D"); exp_q.push_back("A"); exp_q.push_back(",");
        push_num(hms >> 8, 6);
        exp_q.push_back(".");
        push_num({24'h0, hms[7:0]}, 2);
        exp_q.push_back(",");
        push_num({24'h0, dd}, 2);
        exp_q.push_back(",");
        push_num({24'h0, mo}, 2);
        exp_q.push_back(",");
        push_num({16'h0, yy}, 4);
        exp_q.push_back(",");
        push_num({24'h0, zh}, 2);
        exp_q.push_back(",");
        push_num({24'h0, zm}, 2);
        cs = 8'h00;
        for (int i = 1; i < exp_q.size(); i++) cs ^= exp_q[i];
        exp_q.push_back("*");
        exp_q.push_back(hexc(cs[7:4]));
        exp_q.push_back(hexc(cs[3:0]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic vec_to_exp(input logic [303:0] v);
        exp_q = {};
        for (int i = 0; i < 38; i++) exp_q.push_back(v[303 - 8*i -: 8]);
    endtask

    task automatic check_cap(input string name, input bit use_gn);
        logic [7:0] got[$];
        int bad_idx;
        if (use_gn) got = capg; else got = cap;
        total++;
        bad_idx = -1;
        if (got.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s length actual=%0d required=%0d", name, got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got.size(); i++)
                if (bad_idx < 0 && got[i] != exp_q[i]) bad_idx = i;
            if (bad_idx >= 0) begin
                bad++;
                $display("FAIL %s byte %0d actual=%h required=%h", name, bad_idx,
                         got[bad_idx], exp_q[bad_idx]);
            end
        end
    endtask

    task automatic set_fields(input int i);
        bus.hhmmss = tbl[i].hms;
        bus.day    = tbl[i].dd;
        bus.month  = tbl[i].mo;
        bus.year   = tbl[i].yy;
        bus.zone_h = tbl[i].zh;
        bus.zone_m = tbl[i].zm;
    endtask

    task automatic start_sentence(input logic h);
        bus.start = 1'b1;
        bus.hold  = h;
        clear_cap();
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        while (done_cyc < 0 && cyc < limit) tick();
        check_eq("done_seen", int'(done_cyc >= 0), 1);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_load"}, int'(bus.load), 0);
        check_eq({tag, "_data"}, int'(bus.data), 0);
        check_eq({tag, "_busy"}, int'(bus.busy), 0);
        check_eq({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        int holds;
        logic h;

        tbl[0] = '{hms: 32'h12345678, dd: 8'h09, mo: 8'h10, yy: 16'h2021, zh: 8'h00, zm: 8'h00,
                   gp: {"$GPZDA,123456.78,09,10,2021,00,00*67", 8'h0D, 8'h0A},
                   gn: {"$GNZDA,123456.78,09,10,2021,00,00*79", 8'h0D, 8'h0A}};
        tbl[1] = '{hms: 32'h00000000, dd: 8'h00, mo: 8'h00, yy: 16'h0000, zh: 8'h00, zm: 8'h00,
                   gp: {"$GPZDA,000000.00,00,00,0000,00,00*66", 8'h0D, 8'h0A},
                   gn: {"$GNZDA,000000.00,00,00,0000,00,00*78", 8'h0D, 8'h0A}};
        tbl[2] = '{hms: 32'h23595999, dd: 8'h31, mo: 8'h12, yy: 16'h1999, zh: 8'h05, zm: 8'h30,
                   gp: {"$GPZDA,235959.99,31,12,1999,05,30*68", 8'h0D, 8'h0A},
                   gn: {"$GNZDA,235959.99,31,12,1999,05,30*76", 8'h0D, 8'h0A}};

        restart   = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        set_fields(0);
        clear_cap();
        repeat (3) tick();
        check_idle_zero("reset");
        restart = 1'b0;
        tick();
        check_eq("idle_load", int'(bus.load), 0);

        // Directed table
        for (int i = 0; i < 3; i++) begin
            set_fields(i);
            start_sentence(1'b0);
            wait_done(100);
            vec_to_exp(tbl[i].gp);
            check_cap("tbl_gp", 1'b0);
            vec_to_exp(tbl[i].gn);
            check_cap("tbl_gn", 1'b1);
            model(TK_GP, tbl[i].hms, tbl[i].dd, tbl[i].mo, tbl[i].yy, tbl[i].zh, tbl[i].zm);
            check_cap("model_gp", 1'b0);
            check_eq("tbl_first_cyc", first_cyc, 1);
            check_eq("tbl_done_cyc", done_cyc, 38);
            check_eq("tbl_busy_cnt", busy_cnt, 37);
            check_eq("tbl_bubbles", bubbles, 0);
        end
        tick();
        check_eq("post_busy", int'(bus.busy), 0);

        // Hold for three edges while idx 10 is pending
        set_fields(0);
        start_sentence(1'b0);
        while (cap.size() < 10 && cyc < 60) tick();
        bus.hold = 1'b1;
        repeat (3) tick();
        bus.hold = 1'b0;
        wait_done(100);
        vec_to_exp(tbl[0].gp);
        check_cap("hold_seq", 1'b0);
        check_eq("hold_bubbles", bubbles, 3);
        check_eq("hold_done_cyc", done_cyc, 41);

        // Hold on the accept edge defers '$'
        start_sentence(1'b1);
        check_eq("hacc_busy", int'(bus.busy), 1);
        check_eq("hacc_load", int'(bus.load), 0);
        tick();
        bus.hold = 1'b0;
        wait_done(100);
        check_cap("hacc_seq", 1'b0);
        check_eq("hacc_first_cyc", first_cyc, 3);
        check_eq("hacc_done_cyc", done_cyc, 40);

        // Mid-sentence start ignored, then back-to-back start in the done cycle
        start_sentence(1'b0);
        while (cap.size() < 15 && cyc < 60) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(100);
        check_cap("b2b_first_seq", 1'b0);
        check_eq("b2b_first_done", done_cyc, 38);
        start_sentence(1'b0);
        check_eq("b2b_zero_gap_load", int'(bus.load), 1);
        check_eq("b2b_zero_gap_data", int'(bus.data), 8'h24);
        wait_done(100);
        check_cap("b2b_second_seq", 1'b0);
        check_eq("b2b_second_done", done_cyc, 38);
        tick();

        // Restart mid-sentence abandons it and clears the checksum
        start_sentence(1'b0);
        while (cap.size() < 20 && cyc < 60) tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_idle_zero("rst_mid");
        repeat (3) tick();
        check_eq("rst_stays_idle", int'(bus.busy), 0);
        check_eq("rst_no_resume", cap.size(), 20);
        start_sentence(1'b0);
        wait_done(100);
        check_cap("rst_new_seq", 1'b0);
        check_eq("rst_new_done", done_cyc, 38);
        tick();

        // Fields are latched at accept
        set_fields(0);
        start_sentence(1'b0);
        bus.day = 8'h31;
        wait_done(100);
        check_cap("latch_seq", 1'b0);
        set_fields(0);
        tick();

        // Random fields, hold and spurious starts against the sentence model
        for (int n = 0; n < 30; n++) begin
            bus.hhmmss = $urandom;
            bus.day    = 8'($urandom);
            bus.month  = 8'($urandom);
            bus.year   = 16'($urandom);
            bus.zone_h = 8'($urandom);
            bus.zone_m = 8'($urandom);
            holds = 0;
            bus.start = 1'b1;
            clear_cap();
            do begin
                h = ($urandom_range(0, 3) == 0);
                bus.hold = h;
                tick();
                bus.start = ($urandom_range(0, 7) == 0);
                if (h) holds++;
            end while (done_cyc < 0 && cyc < 400);
            bus.start = 1'b0;
            bus.hold  = 1'b0;
            check_eq("rnd_done_seen", int'(done_cyc >= 0), 1);
            model(TK_GP, bus.hhmmss, bus.day, bus.month, bus.year, bus.zone_h, bus.zone_m);
            check_cap("rnd_gp", 1'b0);
            model(TK_GN, bus.hhmmss, bus.day, bus.month, bus.year, bus.zone_h, bus.zone_m);
            check_cap("rnd_gn", 1'b1);
            check_eq("rnd_done_cyc", done_cyc, 38 + holds);
            check_eq("rnd_bubbles", bubbles, holds);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
